axi_rd_engine: RTL and testbench
================================

Name: axi_rd_engine

Overview:
- AXI-side read responder for the prefetcher/Dcache read-request interface.
- Accepts one read request at a time: uncached word, one 128-bit line, or a 256-bit double line (line plus next-line prefetch).
- Issues the matching AXI4 INCR burst and assembles the 32-bit R beats into a 256-bit return buffer.
- Pulses ret_half when the lower 128 bits of a double-line read are ready, and ret_valid when the request completes.

Parameters:
- AXI_ID, 4'd0, value driven on arid.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- rd_req  in  1  read request valid
- rd_type  in  2  00 word, 01 line (128b), 10 double line (256b), 11 treated as 10
- rd_addr  in  32  byte address
- rd_rdy  out  1  engine idle, request accepted when rd_req&&rd_rdy
- ret_valid  out  1  one-cycle pulse, request complete
- ret_data  out  256  assembled data; beat n at [32n+31:32n]
- ret_half  out  1  one-cycle pulse, ret_data[127:0] valid (type 10 only)
- arid  out  4  = AXI_ID
- araddr  out  32  burst start address
- arlen  out  8  beats-1
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 INCR
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  response
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- FSM states: IDLE, AR, RDATA, DONE.
- Reset: state IDLE, arvalid=0, rready=0, ret_valid=0, ret_half=0, ret_data=0, beat counter=0.
- Reset mid-operation aborts the request with no ret_valid.
- IDLE: rd_rdy=1. On rd_req, latch type and address, clear the buffer to 0 and the counter to 0, then go to AR. rd_rdy=0 in all other states.
- AR: arvalid=1. araddr, arlen, and arvalid are held stable until arready. On arvalid&&arready go to RDATA.
  - Type 00: araddr=rd_addr, arlen=0.
  - Type 01: araddr={rd_addr[31:4],4'b0}, arlen=3.
  - Type 10/11: araddr={rd_addr[31:5],5'b0}, arlen=7.
- RDATA: rready=1. Each rvalid beat writes rdata to buffer slot counter[2:0], then increments the counter.
  - The counter saturates at 7; extra beats overwrite slot 7.
  - Type 10: on the beat written into slot 3, ret_half=1 in the following cycle, exactly once per request.
  - Any beat with rlast=1 goes to DONE. Completion is driven by rlast only, not by beat count; slots not written stay 0.
- DONE: ret_valid=1 for exactly this cycle, then IDLE.
- Request latency: earliest rd_rdy=1 is the cycle after DONE.
- ret_data is stable from DONE until the next accepted request clears it.
- ret_half and ret_valid are never asserted in the same cycle, even if beat 3 and rlast coincide (malformed burst). In that case ret_half is suppressed.
- Simultaneous rd_req in DONE is not accepted; it is taken in the following IDLE cycle if still held.
- rresp is ignored unless the optional feature is enabled.

Optional Feature:
- Macro RD_ERR_CHK_EN.
- Defined:
  - Adds output ret_err (1 bit), reset 0.
  - A sticky error flag is cleared on request accept and set by any beat with rresp!=2'b00.
  - ret_err equals the flag during the DONE cycle, otherwise 0.
- Undefined: the ret_err port and all error logic are absent; rresp is unused.

Test Plan:
- Type 00, rd_addr=0x1FC0_0004, arready immediate, rdata=0xDEADBEEF rlast=1 -> araddr=0x1FC0_0004, arlen=0, ret_valid one cycle, ret_data[31:0]=0xDEADBEEF, upper bits 0.
- Type 01, rd_addr=0x0000_1238, beats 0x11,0x22,0x33,0x44 -> araddr=0x0000_1230, arlen=3, ret_data[127:0]=0x00000044_00000033_00000022_00000011, no ret_half.
- Type 10, rd_addr=0x0000_2014, 8 beats 0..7, rvalid toggling every other cycle -> araddr=0x0000_2000, arlen=7, ret_half one cycle after beat 3, ret_valid after beat 7, ret_data[255:224]=7.
- arready delayed 5 cycles -> arvalid and araddr stable for all 5 cycles, rready=0, rd_rdy=0.
- reset asserted during RDATA after 2 beats -> next cycle IDLE, rd_rdy=1, ret_data=0, no ret_valid pulse.
- With RD_ERR_CHK_EN, type 01 with beat 2 rresp=2'b10 -> ret_err=1 with ret_valid; next clean request gives ret_err=0.

Source files
------------

// File: rtl/axi_rd_engine.sv
// ============================================================================
//  Module      : axi_rd_engine
//  Description : AXI4 read responder for prefetcher/Dcache requests; issues a
//                word, line or double-line INCR burst and assembles a 256-bit
//                return buffer. Optional macro RD_ERR_CHK_EN adds ret_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_engine #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [1:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [255:0] ret_data,
    output logic         ret_half,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
`ifdef RD_ERR_CHK_EN
    ,
    output logic         ret_err
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_AR    = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] c_last_slot = 3'd7;
    localparam logic [2:0] c_half_slot = 3'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_next;
    logic [1:0]   r_type;
    logic [31:0]  r_addr;
    logic [2:0]   r_cnt;
    logic [255:0] r_buf;
    logic         r_half;
    logic         w_accept;
    logic         w_beat;

    assign w_accept = (r_state == S_IDLE) && rd_req;
    assign w_beat   = (r_state == S_RDATA) && rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (rd_req)           w_next = S_AR;
            S_AR:    if (arready)          w_next = S_RDATA;
            S_RDATA: if (rvalid && rlast)  w_next = S_DONE;
            S_DONE:                        w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        case (r_state)
            S_IDLE:  rd_rdy    = 1'b1;
            S_AR:    arvalid   = 1'b1;
            S_RDATA: rready    = 1'b1;
            S_DONE:  ret_valid = 1'b1;
            default: rd_rdy    = 1'b0;
        endcase
    end

    // Type 11 decodes as a double line, hence the default arm.
    always_comb begin
        araddr = r_addr;
        arlen  = 8'd0;
        case (r_type)
            2'b00: begin
                araddr = r_addr;
                arlen  = 8'd0;
            end
            2'b01: begin
                araddr = {r_addr[31:4], 4'b0000};
                arlen  = 8'd3;
            end
            default: begin
                araddr = {r_addr[31:5], 5'b00000};
                arlen  = 8'd7;
            end
        endcase
    end

    assign arid    = AXI_ID;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // A half pulse that would land on the DONE cycle is dropped so the two
    // completion strobes never overlap on a malformed burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_type <= 2'b00;
            r_addr <= 32'd0;
            r_cnt  <= 3'd0;
            r_buf  <= 256'd0;
            r_half <= 1'b0;
        end else begin
            r_half <= w_beat && r_type[1] && (r_cnt == c_half_slot) && !rlast;
            if (w_accept) begin
                r_type <= rd_type;
                r_addr <= rd_addr;
                r_cnt  <= 3'd0;
                r_buf  <= 256'd0;
            end else if (w_beat) begin
                r_buf[{r_cnt, 5'b00000} +: 32] <= rdata;
                if (r_cnt != c_last_slot) begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    assign ret_data = r_buf;
    assign ret_half = r_half;

`ifdef RD_ERR_CHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_beat && (rresp != 2'b00)) begin
            r_err <= 1'b1;
        end
    end

    assign ret_err = (r_state == S_DONE) && r_err;

    logic w_unused;
    assign w_unused = ^rid;
`else
    logic w_unused;
    assign w_unused = ^{rid, rresp};
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_engine.sv
// ============================================================================
//  Module      : tb_axi_rd_engine
//  Description : Directed, table-driven self-checking bench for axi_rd_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_rd_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [1:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         ret_half;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
`ifdef RD_ERR_CHK_EN
    logic         ret_err;
`endif

    axi_rd_engine #(.AXI_ID(4'd0)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_half(ret_half),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
`ifdef RD_ERR_CHK_EN
        , .ret_err(ret_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int vpulse = 0;

    always @(posedge clk) begin
        if (ret_valid === 1'b1) vpulse <= vpulse + 1;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        int          nbeats;
        int          ar_delay;
        bit          toggle;
        logic [31:0] d0;
        logic [31:0] dstep;
        int          err_beat;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        int          exp_half;
        bit          exp_err;
    } vec_t;

    vec_t vecs[9];

    // Runs one complete request; entered and left on an IDLE-state negedge.
    task automatic run_vec(input vec_t v);
        logic [255:0] model;
        logic [31:0]  d;
        int           half_cnt;
        int           slot;
        model    = '0;
        half_cnt = 0;
        chk("rd_rdy_idle", rd_rdy, 1);
        rd_req  = 1'b1;
        rd_type = v.typ;
        rd_addr = v.addr;
        @(negedge clk);
        rd_req  = 1'b0;
        rd_type = 2'b00;
        rd_addr = 32'hFFFF_FFFF;
        for (int k = 0; k < v.ar_delay; k++) begin
            chk("ar_wait_arvalid", arvalid, 1);
            chk("ar_wait_araddr", araddr, v.exp_araddr);
            chk("ar_wait_rready", rready, 0);
            chk("ar_wait_rd_rdy", rd_rdy, 0);
            @(negedge clk);
        end
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, v.exp_araddr);
        chk("arlen", arlen, v.exp_arlen);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("rready", rready, 1);
        chk("arvalid_drop", arvalid, 0);
        for (int i = 0; i < v.nbeats; i++) begin
            if (v.toggle) begin
                rvalid = 1'b0;
                @(negedge clk);
                chk("half_idle", ret_half, 0);
            end
            d      = v.d0 + v.dstep * i;
            rvalid = 1'b1;
            rdata  = d;
            rlast  = (i == v.nbeats - 1);
            rresp  = (i == v.err_beat) ? 2'b10 : 2'b00;
            slot   = (i > 7) ? 7 : i;
            model[slot*32 +: 32] = d;
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            if (ret_half === 1'b1) half_cnt++;
            if (i != v.nbeats - 1) begin
                chk("ret_half", ret_half, (slot == 3) && v.typ[1]);
                chk("ret_valid_early", ret_valid, 0);
            end else begin
                chk("ret_valid_done", ret_valid, 1);
                chk("half_in_done", ret_half, 0);
                chk("ret_data", ret_data, model);
                chk("rd_rdy_done", rd_rdy, 0);
`ifdef RD_ERR_CHK_EN
                chk("ret_err", ret_err, v.exp_err);
`endif
            end
        end
        chk("half_count", half_cnt, v.exp_half);
        @(negedge clk);
        chk("ret_valid_pulse_end", ret_valid, 0);
        chk("rd_rdy_after", rd_rdy, 1);
        chk("ret_data_hold", ret_data, model);
`ifdef RD_ERR_CHK_EN
        chk("ret_err_idle", ret_err, 0);
`endif
    endtask

    initial begin
        int vp0;
        //            typ    addr          n  dly tog d0            step   err  araddr        len   half err
        vecs[0] = '{2'b00, 32'h1FC0_0004,  1, 0, 1'b0, 32'hDEADBEEF, 32'h0,  -1, 32'h1FC0_0004, 8'd0, 0, 1'b0};
        vecs[1] = '{2'b01, 32'h0000_1238,  4, 0, 1'b0, 32'h11,       32'h11, -1, 32'h0000_1230, 8'd3, 0, 1'b0};
        vecs[2] = '{2'b10, 32'h0000_2014,  8, 0, 1'b1, 32'h0,        32'h1,  -1, 32'h0000_2000, 8'd7, 1, 1'b0};
        vecs[3] = '{2'b01, 32'h0000_ABCC,  4, 5, 1'b0, 32'hA0,       32'h1,  -1, 32'h0000_ABC0, 8'd3, 0, 1'b0};
        vecs[4] = '{2'b10, 32'h0000_3004,  4, 0, 1'b0, 32'h100,      32'h1,  -1, 32'h0000_3000, 8'd7, 0, 1'b0};
        vecs[5] = '{2'b11, 32'h0000_403F,  2, 0, 1'b0, 32'h50,       32'h1,  -1, 32'h0000_4020, 8'd7, 0, 1'b0};
        vecs[6] = '{2'b01, 32'h0000_5004, 10, 0, 1'b0, 32'h60,       32'h1,  -1, 32'h0000_5000, 8'd3, 0, 1'b0};
        vecs[7] = '{2'b01, 32'h0000_6008,  4, 0, 1'b0, 32'h70,       32'h1,   2, 32'h0000_6000, 8'd3, 0, 1'b1};
        vecs[8] = '{2'b00, 32'h0000_7001,  1, 0, 1'b0, 32'h80,       32'h0,  -1, 32'h0000_7001, 8'd0, 0, 1'b0};

        reset = 1'b1; rd_req = 1'b0; rd_type = 2'b00; rd_addr = 32'h0;
        arready = 1'b0; rid = 4'h5; rdata = 32'h0; rresp = 2'b00;
        rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_rdy", rd_rdy, 1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_half", ret_half, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 4'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 9; n++) run_vec(vecs[n]);

        // Reset in the middle of a data phase abandons the request.
        rd_req = 1'b1; rd_type = 2'b10; rd_addr = 32'h0000_8000;
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_0001;
        @(negedge clk);
        rdata = 32'hAAAA_0002;
        @(negedge clk);
        rvalid = 1'b0; reset = 1'b1; vp0 = vpulse;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_rd_rdy", rd_rdy, 1);
        chk("abort_ret_data", ret_data, 0);
        chk("abort_ret_valid", ret_valid, 0);
        chk("abort_rready", rready, 0);
        @(negedge clk);
        chk("abort_no_pulse", vpulse, vp0);

        // A request raised during DONE waits for the following IDLE cycle.
        rd_req = 1'b1; rd_type = 2'b00; rd_addr = 32'h9000_0010;
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        chk("hold_done_valid", ret_valid, 1);
        chk("hold_done_rd_rdy", rd_rdy, 0);
        rd_req = 1'b1; rd_type = 2'b01; rd_addr = 32'hA000_0044;
        @(negedge clk);
        chk("hold_idle_rd_rdy", rd_rdy, 1);
        chk("hold_idle_arvalid", arvalid, 0);
        chk("hold_idle_data", ret_data, 256'h1234_5678);
        @(negedge clk);
        rd_req = 1'b0;
        chk("hold_ar_arvalid", arvalid, 1);
        chk("hold_ar_araddr", araddr, 32'hA000_0040);
        chk("hold_ar_arlen", arlen, 8'd3);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0000_0005;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        chk("hold_second_valid", ret_valid, 1);
        chk("hold_second_data", ret_data, 256'h5);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
